// File: rtl/t_mod_counter_if.sv
// ----------------------------------------------------------------------------
// t_mod_counter_if
// Control and status bundle for one modulo-N counter digit.
//   en        count enable
//   up_dn     direction, 1 = up, 0 = down
//   load      synchronous parallel load strobe
//   load_val  value to load (clamped to MODULUS-1 by the counter)
//   count     registered counter value
//   t_vec     per-bit toggle enables for the next edge
//   tc        combinational terminal count (cascade enable for next digit)
//   wrap      registered one-cycle pulse after a wrap-around edge
// Modports: master drives controls and observes status; slave is the counter.
// ----------------------------------------------------------------------------
interface t_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  count, t_vec, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, t_vec, tc, wrap
    );
endinterface

// File: rtl/t_mod_counter.sv
// ----------------------------------------------------------------------------
// t_mod_counter
// Synchronous modulo-MODULUS up/down counter expressed as per-bit toggles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (count=0, wrap=0)
//   bus    t_mod_counter_if.slave: en/up_dn/load/load_val in,
//          count/t_vec/tc/wrap out
// Priority per edge: load, then en, then hold.
// ----------------------------------------------------------------------------
module t_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    t_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;

    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (bus.load) begin
            w_count_next = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (r_count == MAX_VAL) begin
                    w_count_next = '0;
                    w_wrap_next  = 1'b1;
                end else if (r_count > MAX_VAL) begin
                    // recover from an illegal state without flagging a wrap
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    w_count_next = MAX_VAL;
                    w_wrap_next  = 1'b1;
                end else if (r_count > MAX_VAL) begin
                    w_count_next = MAX_VAL;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // Toggle enables fall out of the next-state value, so they track the
    // modulo wrap and the load path exactly.
    assign bus.t_vec = w_count_next ^ r_count;
    assign bus.tc    = bus.en & ~bus.load &
                       (bus.up_dn ? (r_count == MAX_VAL) : (r_count == '0));
    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_t_mod_counter.sv
module tb_t_mod_counter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    t_mod_counter_if #(.WIDTH(4)) bus0 ();
    t_mod_counter_if #(.WIDTH(4)) bus_lo ();
    t_mod_counter_if #(.WIDTH(4)) bus_hi ();

    t_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    t_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lo)
    );

    t_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi)
    );

    assign bus_hi.en = bus_lo.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic hi_wrap_seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus0.en = 1'b0; bus0.up_dn = 1'b1; bus0.load = 1'b0; bus0.load_val = 4'd0;
        bus_lo.en = 1'b0; bus_lo.up_dn = 1'b1; bus_lo.load = 1'b0; bus_lo.load_val = 4'd0;
        bus_hi.up_dn = 1'b1; bus_hi.load = 1'b0; bus_hi.load_val = 4'd0;
        #12;
        check("reset_count", 32'(bus0.count), 0);
        check("reset_wrap", 32'(bus0.wrap), 0);
        rst_n = 1'b1;

        // async reset mid-cycle with a pending load
        bus0.load = 1'b1; bus0.load_val = 4'd7;
        step();
        check("pre_rst_load7", 32'(bus0.count), 7);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bus0.count), 0);
        check("async_rst_wrap", 32'(bus0.wrap), 0);
        bus0.load = 1'b0;
        rst_n = 1'b1;
        step(); check("hold_e1", 32'(bus0.count), 0);
        step(); check("hold_e2", 32'(bus0.count), 0);
        step(); check("hold_e3", 32'(bus0.count), 0);

        // count up through the wrap
        bus0.en = 1'b1; bus0.up_dn = 1'b1;
        #1;
        check("tc_up_at0", 32'(bus0.tc), 0);
        step(); check("up_1", 32'(bus0.count), 1); check("up_1_wrap", 32'(bus0.wrap), 0);
        step(); check("up_2", 32'(bus0.count), 2);
        step(); check("up_3", 32'(bus0.count), 3);
        step(); step(); step(); step(); step();
        check("up_8", 32'(bus0.count), 8);
        check("tc_up_at8", 32'(bus0.tc), 0);
        step(); check("up_9", 32'(bus0.count), 9);
        check("tc_up_at9", 32'(bus0.tc), 1);
        check("wrap_at9", 32'(bus0.wrap), 0);
        step(); check("up_wrap_count", 32'(bus0.count), 0);
        check("up_wrap_pulse", 32'(bus0.wrap), 1);
        bus0.en = 1'b0;
        #1;
        check("tc_en0", 32'(bus0.tc), 0);
        step(); check("wrap_drop", 32'(bus0.wrap), 0);

        // count down through the wrap
        bus0.en = 1'b1; bus0.up_dn = 1'b0;
        #1;
        check("tc_dn_at0", 32'(bus0.tc), 1);
        step(); check("dn_wrap_count", 32'(bus0.count), 9);
        check("dn_wrap_pulse", 32'(bus0.wrap), 1);
        check("tc_dn_at9", 32'(bus0.tc), 0);
        step(); check("dn_8", 32'(bus0.count), 8); check("dn_8_wrap", 32'(bus0.wrap), 0);
        step(); check("dn_7", 32'(bus0.count), 7);

        // direction change with no dead cycle
        bus0.up_dn = 1'b1;
        step(); check("dir_up_8", 32'(bus0.count), 8);

        // load priority and clamp
        bus0.load = 1'b1; bus0.load_val = 4'd5; bus0.up_dn = 1'b0;
        #1;
        check("tc_load", 32'(bus0.tc), 0);
        check("tvec_load", 32'(bus0.t_vec), 32'h0D);
        step(); check("load_5", 32'(bus0.count), 5); check("load_5_wrap", 32'(bus0.wrap), 0);
        bus0.load_val = 4'd12;
        step(); check("load_clamp", 32'(bus0.count), 9);

        // toggle vectors
        bus0.load_val = 4'd3;
        step();
        bus0.load = 1'b0; bus0.en = 1'b1; bus0.up_dn = 1'b1;
        #1;
        check("tvec_3", 32'(bus0.t_vec), 32'h7);
        bus0.en = 1'b0;
        #1;
        check("tvec_en0", 32'(bus0.t_vec), 0);
        bus0.load = 1'b1; bus0.load_val = 4'd7;
        step();
        bus0.load = 1'b0; bus0.en = 1'b1;
        #1;
        check("tvec_7", 32'(bus0.t_vec), 32'hF);
        bus0.load = 1'b1; bus0.load_val = 4'd9;
        step();
        bus0.load = 1'b0;
        #1;
        check("tvec_9_up", 32'(bus0.t_vec), 32'h9);
        bus0.up_dn = 1'b0;
        #1;
        check("tvec_9_dn", 32'(bus0.t_vec), 32'h1);
        bus0.en = 1'b0;

        // two-digit cascade
        bus_lo.load = 1'b1; bus_lo.load_val = 4'd0;
        bus_hi.load = 1'b1; bus_hi.load_val = 4'd0;
        step();
        bus_lo.load = 1'b0; bus_hi.load = 1'b0;
        bus_lo.en = 1'b1;
        hi_wrap_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus_hi.wrap !== 1'b0) hi_wrap_seen = 1'b1;
        end
        bus_lo.en = 1'b0;
        #1;
        check("cascade_lo", 32'(bus_lo.count), 5);
        check("cascade_hi", 32'(bus_hi.count), 2);
        check("cascade_hi_wrap", 32'(hi_wrap_seen), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
